lagd_spi_cmd_rx: RTL
====================

LAGD_SPI_CMD_RX -- requirements
Module: lagd_spi_cmd_rx

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, command address width (multiple of 4).
REQ-002 SHALL have parameter DataWidth, default 32, write/read data width (multiple of 4).
REQ-003 SHALL have parameter DummyCycles, default 8, SCK cycles between the end of the read address and the first read-data nibble.
REQ-004 SHALL have parameter SyncStages, default 2, synchronizer depth on SCK, CSN and SDI.
REQ-005 SHALL have port clk_i  in  1  system clock; the single clock of the block.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port spi_sck_i  in  1  SPI clock, asynchronous, sampled by clk_i.
REQ-008 SHALL have port spi_csn_i  in  1  chip select, active-low.
REQ-009 SHALL have port spi_sdi_i  in  4  quad data in.
REQ-010 SHALL have port spi_sdo_o  out  4  quad data out.
REQ-011 SHALL have port spi_oen_o  out  4  output enable, active-low (0 = drive).
REQ-012 SHALL have port cmd_valid_o  out  1  command valid toward the downstream AXI master.
REQ-013 SHALL have port cmd_ready_i  in  1  command accepted.
REQ-014 SHALL have port cmd_write_o  out  1  1 = write, 0 = read.
REQ-015 SHALL have port cmd_addr_o  out  AddrWidth  command address.
REQ-016 SHALL have port cmd_wdata_o  out  DataWidth  write data (0 for reads).
REQ-017 SHALL have port rsp_valid_i  in  1  response valid.
REQ-018 SHALL have port rsp_rdata_i  in  DataWidth  read data.
REQ-019 SHALL have port rsp_ready_o  out  1  response accept; constant 1.
REQ-020 SHALL have port frame_err_o  out  1  one-cycle pulse on any protocol error.

Function
REQ-021 SHALL resynchronize SCK, CSN and SDI through SyncStages flops, detecting SCK edges on the synchronized copy; spec holds for f(SCK) <= f(clk_i)/4.
REQ-022 SHALL sample one nibble, MSB first, on each detected SCK rising edge while CSN is low.
REQ-023 SHALL run the FSM IDLE -> OPCODE (2 nibbles) -> ADDR (AddrWidth/4) -> WDATA (DataWidth/4, opcode 0x02) or DUMMY (DummyCycles, opcode 0x0B) -> RDATA (DataWidth/4) -> DONE.
REQ-024 SHALL enter DROP on any other opcode, pulse frame_err_o, and ignore SCK until CSN rises.
REQ-025 SHALL leave IDLE on the synchronized CSN falling edge and return to IDLE from any state in the cycle after the synchronized CSN rises; the partial frame is discarded and no command is issued.
REQ-026 SHALL raise cmd_valid_o on the clk_i cycle after the sample of the final WDATA nibble (write) or final ADDR nibble (read).
REQ-027 SHALL hold cmd_valid_o, cmd_write_o, cmd_addr_o and cmd_wdata_o stable until cmd_valid_o && cmd_ready_i, then drop cmd_valid_o the next cycle.
REQ-028 SHALL, if a new command completes while cmd_valid_o is still high, drop the new command, keep the pending one unchanged, and pulse frame_err_o.
REQ-029 SHALL capture rsp_rdata_i into the read buffer when rsp_valid_i is high and a read is outstanding; responses arriving when no read is outstanding (write acks) SHALL be discarded.
REQ-030 SHALL, at the end of DUMMY, load the read buffer into the output shift register; if no response has arrived, it SHALL load 0 and pulse frame_err_o.
REQ-031 SHALL update spi_sdo_o on each detected SCK falling edge in RDATA, with the first nibble valid before the first RDATA rising edge, MSB first.
REQ-032 SHALL drive spi_oen_o = 4'b0000 only in RDATA and 4'b1111 otherwise; spi_sdo_o SHALL be 0 when not enabled.
REQ-033 SHALL ignore SCK edges in DONE (extra clocks) until CSN rises, with no error.

Reset
REQ-034 SHALL, on rst_ni low, force state IDLE, cmd_valid_o=0, cmd_write_o=0, cmd_addr_o=0, cmd_wdata_o=0, spi_sdo_o=0, spi_oen_o=4'b1111, frame_err_o=0, clear the read buffer and outstanding flag, and preset the synchronizers to SCK=0, CSN=1.
REQ-035 SHALL abort any frame or pending command when reset is asserted mid-operation; no command is issued after reset release until a new complete frame arrives.

Verification
REQ-036 SHALL verify a write: opcode 0x02, addr 0x1000_0040, data 0xDEAD_BEEF, cmd_ready_i=1 -> one cmd_valid_o pulse with write=1, addr 0x1000_0040, wdata 0xDEADBEEF.
REQ-037 SHALL verify a read: opcode 0x0B, addr 0x7000_0000, rsp 0x1234_5678 returned 3 cycles after cmd acceptance -> SDO nibbles 1,2,...,8 after 8 dummy cycles with oen=0 only during RDATA.
REQ-038 SHALL verify a late response: read with rsp withheld past DUMMY -> SDO outputs 0x00000000 and frame_err_o pulses once.
REQ-039 SHALL verify backpressure: cmd_ready_i=0 held, two write frames sent -> first command stays stable, second is dropped, frame_err_o pulses once.
REQ-040 SHALL verify an abort and a bad opcode: CSN raised after 5 ADDR nibbles -> no cmd_valid_o; opcode 0x55 -> frame_err_o pulse, no command, and the next valid frame decodes correctly.

Source files
------------

// File: rtl/lagd_spi_cmd_rx.sv
// lagd_spi_cmd_rx: quad-SPI slave that turns write/read frames into a
// single command toward a downstream bus master and serves the read
// response back over SDO. SCK, CSN and SDI are oversampled by clk_i.
//
// Ports:
//   clk_i, rst_ni            system clock, async active-low reset
//   spi_sck_i/csn_i/sdi_i    SPI inputs (asynchronous to clk_i)
//   spi_sdo_o, spi_oen_o     quad data out, active-low output enable
//   cmd_*                    command valid/ready handshake and payload
//   rsp_*                    read response input (always accepted)
//   frame_err_o              one-cycle pulse on any protocol error
//
// state  | meaning
// IDLE   | waiting for CSN to fall
// OPCODE | shifting in the 2 opcode nibbles
// ADDR   | shifting in AddrWidth/4 address nibbles
// WDATA  | shifting in DataWidth/4 write-data nibbles
// DUMMY  | counting DummyCycles SCK cycles before read data
// RDATA  | driving DataWidth/4 read nibbles on SDO
// DONE   | frame complete, extra SCK ignored until CSN rises
// DROP   | bad opcode, SCK ignored until CSN rises
module lagd_spi_cmd_rx #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int DummyCycles = 8,
    parameter int SyncStages  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 spi_sck_i,
    input  logic                 spi_csn_i,
    input  logic [3:0]           spi_sdi_i,
    output logic [3:0]           spi_sdo_o,
    output logic [3:0]           spi_oen_o,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic                 cmd_write_o,
    output logic [AddrWidth-1:0] cmd_addr_o,
    output logic [DataWidth-1:0] cmd_wdata_o,
    input  logic                 rsp_valid_i,
    input  logic [DataWidth-1:0] rsp_rdata_i,
    output logic                 rsp_ready_o,
    output logic                 frame_err_o
);

    localparam int AddrNib = AddrWidth / 4;
    localparam int DataNib = DataWidth / 4;
    localparam int NibMax  = (AddrNib > DataNib) ? AddrNib : DataNib;
    localparam int CntMax  = (NibMax > DummyCycles) ? NibMax : DummyCycles;
    localparam int CntW    = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE, S_DROP
    } state_e;

    logic [SyncStages-1:0]      sck_sync_q, csn_sync_q;
    logic [SyncStages-1:0][3:0] sdi_sync_q;
    logic                       sck_prev_q, csn_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0;
            csn_sync_q <= '1;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            csn_sync_q <= {csn_sync_q[SyncStages-2:0], spi_csn_i};
            sdi_sync_q <= {sdi_sync_q[SyncStages-2:0], spi_sdi_i};
            sck_prev_q <= sck_sync_q[SyncStages-1];
            csn_prev_q <= csn_sync_q[SyncStages-1];
        end
    end

    logic       sck_s, csn_s, sck_rise, sck_fall, csn_fall;
    logic [3:0] sdi_s;

    assign sck_s    = sck_sync_q[SyncStages-1];
    assign csn_s    = csn_sync_q[SyncStages-1];
    assign sdi_s    = sdi_sync_q[SyncStages-1];
    assign sck_rise = sck_s & ~sck_prev_q & ~csn_s;
    assign sck_fall = ~sck_s & sck_prev_q & ~csn_s;
    assign csn_fall = ~csn_s & csn_prev_q;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic                 is_wr_q, is_wr_d;
    logic [AddrWidth-1:0] addr_sh_q, addr_sh_d;
    logic [DataWidth-1:0] wdata_sh_q, wdata_sh_d;
    logic [DataWidth-1:0] sdo_sh_q, sdo_sh_d;
    logic [DataWidth-1:0] rbuf_q, rbuf_d;
    logic                 rbuf_vld_q, rbuf_vld_d;
    logic                 outst_q, outst_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 cmd_write_q, cmd_write_d;
    logic [AddrWidth-1:0] cmd_addr_q, cmd_addr_d;
    logic [DataWidth-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                 err_q, err_d;

    logic                 issue;
    logic                 issue_wr;
    logic [AddrWidth-1:0] issue_addr;
    logic [DataWidth-1:0] issue_data;
    logic [7:0]           opcode;

    assign opcode = {op_q, sdi_s};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        is_wr_d     = is_wr_q;
        addr_sh_d   = addr_sh_q;
        wdata_sh_d  = wdata_sh_q;
        sdo_sh_d    = sdo_sh_q;
        rbuf_d      = rbuf_q;
        rbuf_vld_d  = rbuf_vld_q;
        outst_d     = outst_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        err_d       = 1'b0;
        issue       = 1'b0;
        issue_wr    = 1'b0;
        issue_addr  = addr_sh_q;
        issue_data  = '0;

        // Response capture first so the DUMMY hand-off below can override it.
        if (rsp_valid_i && outst_q) begin
            rbuf_d     = rsp_rdata_i;
            rbuf_vld_d = 1'b1;
            outst_d    = 1'b0;
        end

        if (state_q != S_IDLE && csn_s) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (csn_fall) begin
                        state_d    = S_OPCODE;
                        cnt_d      = CntW'(1);
                        rbuf_vld_d = 1'b0;
                    end
                end
                S_OPCODE: begin
                    if (sck_rise) begin
                        if (cnt_q == '0) begin
                            cnt_d = CntW'(AddrNib - 1);
                            if (opcode == 8'h02) begin
                                is_wr_d = 1'b1;
                                state_d = S_ADDR;
                            end else if (opcode == 8'h0B) begin
                                is_wr_d = 1'b0;
                                state_d = S_ADDR;
                            end else begin
                                state_d = S_DROP;
                                err_d   = 1'b1;
                            end
                        end else begin
                            op_d  = sdi_s;
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                S_ADDR: begin
                    if (sck_rise) begin
                        addr_sh_d = {addr_sh_q[AddrWidth-5:0], sdi_s};
                        if (cnt_q == '0) begin
                            if (is_wr_q) begin
                                state_d = S_WDATA;
                                cnt_d   = CntW'(DataNib - 1);
                            end else begin
                                issue      = 1'b1;
                                issue_addr = addr_sh_d;
                                state_d    = S_DUMMY;
                                cnt_d      = CntW'(DummyCycles);
                            end
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (sck_rise) begin
                        wdata_sh_d = {wdata_sh_q[DataWidth-5:0], sdi_s};
                        if (cnt_q == '0) begin
                            issue      = 1'b1;
                            issue_wr   = 1'b1;
                            issue_data = wdata_sh_d;
                            state_d    = S_DONE;
                        end else begin
                            cnt_d = cnt_q - CntW'(1);
                        end
                    end
                end
                S_DUMMY: begin
                    // Hand-off happens on the falling edge after the last dummy
                    // rise so nibble 0 is stable before the first RDATA rise.
                    if (sck_rise) begin
                        if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
                    end else if (sck_fall && cnt_q == '0) begin
                        state_d    = S_RDATA;
                        cnt_d      = CntW'(DataNib - 1);
                        sdo_sh_d   = rbuf_vld_q ? rbuf_q : '0;
                        err_d      = ~rbuf_vld_q;
                        rbuf_vld_d = 1'b0;
                        outst_d    = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (sck_rise) begin
                        if (cnt_q == '0) state_d = S_DONE;
                        else             cnt_d   = cnt_q - CntW'(1);
                    end else if (sck_fall) begin
                        sdo_sh_d = {sdo_sh_q[DataWidth-5:0], 4'h0};
                    end
                end
                S_DONE, S_DROP: ;
                default: state_d = S_IDLE;
            endcase
        end

        if (cmd_valid_q && cmd_ready_i) cmd_valid_d = 1'b0;

        if (issue) begin
            if (cmd_valid_q) begin
                err_d = 1'b1;
            end else begin
                cmd_valid_d = 1'b1;
                cmd_write_d = issue_wr;
                cmd_addr_d  = issue_addr;
                cmd_wdata_d = issue_data;
                if (!issue_wr) outst_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            is_wr_q     <= 1'b0;
            addr_sh_q   <= '0;
            wdata_sh_q  <= '0;
            sdo_sh_q    <= '0;
            rbuf_q      <= '0;
            rbuf_vld_q  <= 1'b0;
            outst_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            is_wr_q     <= is_wr_d;
            addr_sh_q   <= addr_sh_d;
            wdata_sh_q  <= wdata_sh_d;
            sdo_sh_q    <= sdo_sh_d;
            rbuf_q      <= rbuf_d;
            rbuf_vld_q  <= rbuf_vld_d;
            outst_q     <= outst_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_q       <= err_d;
        end
    end

    assign spi_oen_o   = (state_q == S_RDATA) ? 4'b0000 : 4'b1111;
    assign spi_sdo_o   = (state_q == S_RDATA) ? sdo_sh_q[DataWidth-1 -: 4] : 4'h0;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_write_o = cmd_write_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_wdata_o = cmd_wdata_q;
    assign rsp_ready_o = 1'b1;
    assign frame_err_o = err_q;

endmodule
